// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
// Bundles the hazard-status inputs and the stall/flush control outputs
// exchanged between the five-stage datapath and the pipeline controller.
//
// Signals (datapath -> controller):
//   id_ex_memread, id_ex_register_rd        load in EX and its destination
//   if_id_register_rs1, if_id_register_rs2  source registers of the ID instruction
//   ex_branch_taken                         branch/jump in EX resolved taken
//   ex_mem_memread, ex_mem_memwrite         load/store occupying MEM
//   dmem_ready                              data memory finishes the MEM access
// Signals (controller -> datapath):
//   pc_write, if_id_write, ex_mem_write, mem_wb_write   register enables
//   if_id_flush, id_ex_flush                            bubble insertion
//   mem_wb_bubble                                       writeback squash
//   dmem_timeout                                        sticky memory error
//   stall_count                                         saturating stall counter
//
// Modports: master = datapath side, slave = controller side.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_ex_memread;
  logic [4:0]       id_ex_register_rd;
  logic [4:0]       if_id_register_rs1;
  logic [4:0]       if_id_register_rs2;
  logic             ex_branch_taken;
  logic             ex_mem_memread;
  logic             ex_mem_memwrite;
  logic             dmem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic             mem_wb_bubble;
  logic             dmem_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_ex_memread, id_ex_register_rd, if_id_register_rs1,
           if_id_register_rs2, ex_branch_taken, ex_mem_memread,
           ex_mem_memwrite, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write,
           mem_wb_write, mem_wb_bubble, dmem_timeout, stall_count
  );

  modport slave (
    input  id_ex_memread, id_ex_register_rd, if_id_register_rs1,
           if_id_register_rs2, ex_branch_taken, ex_mem_memread,
           ex_mem_memwrite, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write,
           mem_wb_write, mem_wb_bubble, dmem_timeout, stall_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Stall/flush sequencer for the five-stage RISC-V pipeline. Resolves
// load-use hazards, taken-branch flushes and multi-cycle data-memory
// accesses, and latches a sticky error if data memory never answers.
//
// Parameters:
//   MEM_TIMEOUT  not-ready MEM_WAIT cycles tolerated before ERROR (>= 1)
//   CNT_W        width of the saturating stall counter
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   pipeline_ctrl_if.slave: hazard inputs in, enables/flushes,
//         dmem_timeout and stall_count out
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;
  logic [CNT_W-1:0]  stall_cnt;

  logic mem_busy;
  logic load_use;

  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_write;
  logic mem_wb_write;
  logic mem_wb_bubble;

  assign mem_busy = (bus.ex_mem_memread | bus.ex_mem_memwrite) & ~bus.dmem_ready;

  // rd==x0 never creates a dependency, since x0 is hardwired to zero
  assign load_use = bus.id_ex_memread
                  & (bus.id_ex_register_rd != 5'd0)
                  & ((bus.id_ex_register_rd == bus.if_id_register_rs1)
                   | (bus.id_ex_register_rd == bus.if_id_register_rs2));

  // Priority chain: reset, ERROR, memory freeze, branch, load-use.
  // A freeze holds every younger stage in place, so a pending branch or
  // load-use is simply re-evaluated on the release cycle.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_write  = 1'b0;
      mem_wb_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (state == ERROR) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (bus.ex_branch_taken) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (load_use) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_flush   = 1'b1;
    end
  end

  // State, wait counter, sticky timeout and stall statistics.
  // A ready response in MEM_WAIT takes precedence over the timeout check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (mem_busy) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= ERROR;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ERROR: begin
          timeout_q <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.if_id_write   = if_id_write;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.ex_mem_write  = ex_mem_write;
  assign bus.mem_wb_write  = mem_wb_write;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.dmem_timeout  = timeout_q;
  assign bus.stall_count   = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl with MEM_TIMEOUT=4 and CNT_W=3.
// Each step pushes its expected outputs onto a scoreboard queue while the
// inputs are driven; the entry is popped and compared mid-cycle.
// Control vector bit order: {pc_write, if_id_write, if_id_flush,
// id_ex_flush, ex_mem_write, mem_wb_write, mem_wb_bubble}.
module tb_pipeline_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 3;

  localparam logic [6:0] C_DEF = 7'b1100110;
  localparam logic [6:0] C_LU  = 7'b0001110;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_FRZ = 7'b0000011;
  localparam logic [6:0] C_ERR = 7'b0000001;
  localparam logic [6:0] C_RST = 7'b0011001;

  typedef struct {
    string               tag;
    logic [6:0]          ctrl;
    logic                timeout;
    logic [TB_CNT_W-1:0] sc;
  } exp_t;

  logic clk;
  logic rst;

  pipeline_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  pipeline_ctrl #(
    .MEM_TIMEOUT(TB_TIMEOUT),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t                sb[$];
  int                  checks   = 0;
  int                  failures = 0;
  logic [TB_CNT_W-1:0] sc_model = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic br, input logic exr,
                       input logic exw, input logic rdy);
    bus.id_ex_memread      = mr;
    bus.id_ex_register_rd  = rd;
    bus.if_id_register_rs1 = rs1;
    bus.if_id_register_rs2 = rs2;
    bus.ex_branch_taken    = br;
    bus.ex_mem_memread     = exr;
    bus.ex_mem_memwrite    = exw;
    bus.dmem_ready         = rdy;
  endtask

  task automatic pushExpected(input string tag, input logic [6:0] ctrl, input logic to);
    exp_t e;
    e.tag     = tag;
    e.ctrl    = ctrl;
    e.timeout = to;
    e.sc      = sc_model;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [6:0] obs;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
    end
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
             bus.ex_mem_write, bus.mem_wb_write, bus.mem_wb_bubble};
      checks++;
      assert (obs === e.ctrl) else begin
        failures++;
        $error("[TB] FAIL %s ctrl observed=%b expected=%b", e.tag, obs, e.ctrl);
      end
      checks++;
      assert (bus.dmem_timeout === e.timeout) else begin
        failures++;
        $error("[TB] FAIL %s dmem_timeout observed=%b expected=%b",
               e.tag, bus.dmem_timeout, e.timeout);
      end
      checks++;
      assert (bus.stall_count === e.sc) else begin
        failures++;
        $error("[TB] FAIL %s stall_count observed=%0d expected=%0d",
               e.tag, bus.stall_count, e.sc);
      end
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, then advance.
  task automatic applyStimulus(input string tag, input logic mr, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic br, input logic exr, input logic exw,
                               input logic rdy, input logic [6:0] ectrl, input logic eto);
    drive(mr, rd, rs1, rs2, br, exr, exw, rdy);
    pushExpected(tag, ectrl, eto);
    if (!ectrl[6] && (sc_model != {TB_CNT_W{1'b1}})) sc_model = sc_model + 1'b1;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string tag);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst      = 1'b1;
    sc_model = '0;
    #1;
    pushExpected(tag, C_RST, 1'b0);
    checkOutput();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;

    $display("[TB] reset and load-use");
    doReset("reset_state");
    applyStimulus("idle",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_DEF, 0);
    applyStimulus("lu_rs1",      1, 5'd5, 5'd5, 5'd3, 0, 0, 0, 1, C_LU,  0);
    applyStimulus("lu_after",    0, 5'd0, 5'd5, 5'd3, 0, 0, 0, 1, C_DEF, 0);
    applyStimulus("lu_rd_zero",  1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_DEF, 0);
    applyStimulus("lu_nomatch",  1, 5'd9, 5'd4, 5'd6, 0, 0, 0, 1, C_DEF, 0);
    applyStimulus("lu_rs2",      1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 1, C_LU,  0);
    applyStimulus("branch_lu",   1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1, C_BR,  0);
    applyStimulus("idle2",       0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_DEF, 0);

    $display("[TB] memory wait");
    doReset("reset_memwait");
    for (int i = 0; i < 3; i++)
      applyStimulus("mem_freeze", 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, C_FRZ, 0);
    applyStimulus("mem_release",  0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, C_DEF, 0);
    applyStimulus("mem_after",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_DEF, 0);
    applyStimulus("store_fast",   0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, C_DEF, 0);
    applyStimulus("store_freeze", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_FRZ, 0);
    applyStimulus("store_rel_lu", 1, 5'd2, 5'd2, 5'd0, 0, 0, 1, 1, C_LU,  0);
    applyStimulus("idle3",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_DEF, 0);

    $display("[TB] freeze over branch");
    doReset("reset_frzbr");
    for (int i = 0; i < 2; i++)
      applyStimulus("frz_branch", 1, 5'd5, 5'd5, 5'd0, 1, 1, 0, 0, C_FRZ, 0);
    applyStimulus("frz_br_rel",   1, 5'd5, 5'd5, 5'd0, 1, 1, 0, 1, C_BR,  0);
    applyStimulus("idle4",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_DEF, 0);

    $display("[TB] timeout and stall_count saturation");
    doReset("reset_timeout");
    for (int i = 0; i < TB_TIMEOUT + 1; i++)
      applyStimulus("to_wait",    0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, C_FRZ, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus("to_error",   i[0], 5'd3, 5'd3, 5'd0, i[1], i[0], 0, i[0], C_ERR, 1);

    $display("[TB] ready on the last allowed cycle");
    doReset("reset_edge");
    for (int i = 0; i < TB_TIMEOUT; i++)
      applyStimulus("edge_wait",  0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, C_FRZ, 0);
    applyStimulus("edge_ready",   0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, C_DEF, 0);
    applyStimulus("edge_after",   0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, C_BR,  0);

    $display("[TB] asynchronous reset mid-wait");
    doReset("reset_async_pre");
    for (int i = 0; i < 2; i++)
      applyStimulus("async_wait", 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, C_FRZ, 0);
    #2;
    rst      = 1'b1;
    sc_model = '0;
    #1;
    pushExpected("async_assert", C_RST, 1'b0);
    checkOutput();
    @(posedge clk);
    #1;
    pushExpected("async_held", C_RST, 1'b0);
    checkOutput();
    rst = 1'b0;
    applyStimulus("async_idle",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_DEF, 0);
    applyStimulus("async_fast",   0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, C_DEF, 0);
    applyStimulus("async_freeze", 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, C_FRZ, 0);
    applyStimulus("async_rel",    0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, C_DEF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage RISC-V pipeline. It generates write enables for the PC and the IF/ID, EX/MEM and MEM/WB pipeline registers, plus flush controls for IF/ID and ID/EX. It resolves three hazard classes:
- load-use data hazards;
- taken-branch control hazards;
- multi-cycle data-memory accesses.

A timeout watchdog latches a sticky error if data memory never responds.

## Interface
- MEM_TIMEOUT, 15, max consecutive MEM_WAIT not-ready cycles before ERROR; legal range ≥1.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_register_rd  in  5  destination register of the instruction in EX
- if_id_register_rs1  in  5  rs1 of the instruction in ID
- if_id_register_rs2  in  5  rs2 of the instruction in ID
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- ex_mem_memread  in  1  load in MEM stage
- ex_mem_memwrite  in  1  store in MEM stage
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID register loads a NOP
- id_ex_flush  out  1  ID/EX register loads a bubble (all control bits 0)
- ex_mem_write  out  1  EX/MEM register enable
- mem_wb_write  out  1  MEM/WB register enable
- mem_wb_bubble  out  1  MEM/WB captures mem_wb_regwrite=0 and mem_wb_memtoreg=0
- dmem_timeout  out  1  sticky error flag, set on entry to ERROR
- stall_count  out  CNT_W  number of cycles with pc_write=0, saturating

## Operation
- State register: RUN, MEM_WAIT, ERROR. Reset value: RUN. Internal wait_cnt resets to 0 and has width $clog2(MEM_TIMEOUT+1).
- Control outputs are combinational from state and inputs. dmem_timeout and stall_count are registered.
- mem_busy = (ex_mem_memread | ex_mem_memwrite) & ~dmem_ready.
- load_use = id_ex_memread & (id_ex_register_rd != 0) & ((id_ex_register_rd == if_id_register_rs1) | (id_ex_register_rd == if_id_register_rs2)).
- Default outputs (no event): all writes 1, flushes 0, bubble 0.
- Event priority: ERROR > mem_busy > ex_branch_taken > load_use.

Freeze response (mem_busy in RUN or MEM_WAIT):
- pc_write, if_id_write and ex_mem_write are 0.
- mem_wb_write=1 with mem_wb_bubble=1, so writeback sees a bubble.
- Both flushes are 0. A branch or load-use condition stays held in place and is re-evaluated on release.

Branch response:
- if_id_flush=1, id_ex_flush=1, all writes 1.
- load_use is ignored because the younger instruction is being flushed.

Load-use response:
- pc_write=0, if_id_write=0, id_ex_flush=1.
- ex_mem_write and mem_wb_write are 1.

State transitions:
- RUN→MEM_WAIT on mem_busy; wait_cnt←0.
- In MEM_WAIT with dmem_ready=0: if wait_cnt==MEM_TIMEOUT-1, go to ERROR; otherwise wait_cnt++.
- In MEM_WAIT with dmem_ready=1: this cycle uses normal RUN evaluation (branch, load-use or default); next state is RUN. dmem_ready wins over a simultaneous timeout.
- ERROR: all writes 0, mem_wb_bubble=1, flushes 0. dmem_timeout←1. Exit only via rst.

stall_count:
- Increments on every clock edge where pc_write=0.
- Holds at 2^CNT_W-1.
- Reset value 0.

While rst=1, outputs are forced to: all writes 0, if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1, dmem_timeout=0, stall_count=0.

## Timing
- Control outputs have zero-cycle latency: they respond in the same cycle the condition appears.
- A load-use stall lasts exactly 1 cycle. The next cycle sees a bubble in EX, so load_use clears.
- Branch flush lasts 1 cycle per taken branch.
- Memory freeze length = 1 (RUN entry cycle) + number of MEM_WAIT not-ready cycles. The release cycle is not a freeze.
- With ready held low, ERROR is entered at the clock edge ending the (MEM_TIMEOUT+1)-th consecutive not-ready cycle. dmem_timeout rises at that edge.
- Reset assertion mid-MEM_WAIT:
  - asynchronously returns state to RUN and clears wait_cnt, dmem_timeout and stall_count;
  - forced outputs apply immediately;
  - the first normal cycle is the one after the first rising edge following deassertion.
- A memory access with dmem_ready=1 in its first MEM cycle never leaves RUN.

## Test plan
- Load-use: id_ex_memread=1, rd=5, rs1=5 → one cycle of pc_write=0, if_id_write=0, id_ex_flush=1, stall_count=1. Repeating with rd=0 → no stall.
- Branch + load-use in the same cycle: ex_branch_taken=1 with load_use true → if_id_flush=1, id_ex_flush=1, pc_write=1, stall_count unchanged.
- Memory wait: load in MEM, dmem_ready low for 3 cycles then high → 3 freeze cycles with mem_wb_bubble=1, release on the 4th cycle, state RUN afterwards, stall_count=3.
- Freeze over branch: mem_busy with ex_branch_taken=1 for 2 cycles → flushes 0 during freeze; on the release cycle if_id_flush=1 and id_ex_flush=1.
- Timeout (MEM_TIMEOUT=4): ready held low → dmem_timeout=1 after the 5th not-ready edge; all writes stay 0 indefinitely. Repeat with ready=1 on the 5th cycle → RUN, no error.
- Async reset: assert rst mid-MEM_WAIT between clock edges → outputs forced immediately, dmem_timeout=0, stall_count=0, state RUN after deassertion.
- stall_count saturation: CNT_W=3, 9 stall cycles → stall_count holds at 7.
